// File: rtl/ysyx_24100029_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding and AXI4 constants.
package ysyx_24100029_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_REFILL_AR = 3'd2,
        S_REFILL_R  = 3'd3,
        S_RESP      = 3'd4
    } icache_state_t;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_4B     = 3'b010;

endpackage

// File: rtl/ysyx_24100029_icache_array.sv
// Direct-mapped storage: data words, tags and valid bits, with one word-write port,
// a line-commit port (tag + valid), a combinational read port and invalidate-all.
module ysyx_24100029_icache_array #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(NUM_LINES),
    parameter int WORD_W     = $clog2(LINE_WORDS),
    parameter int TAG_W      = 30 - IDX_W - WORD_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inval_all,
    input  logic              word_we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic              line_we,
    input  logic [TAG_W-1:0]  line_tag,
    input  logic              line_valid,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic [31:0]       rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic              rd_valid
);

    logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;

    always_ff @(posedge clock) begin
        if (word_we) data_mem[{wr_idx, wr_word}] <= wr_data;
        if (line_we) tag_mem[wr_idx] <= line_tag;
    end

    // Invalidate-all outranks a line commit landing on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)         valid_q <= '0;
        else if (inval_all) valid_q <= '0;
        else if (line_we)   valid_q[wr_idx] <= line_valid;
    end

    assign rd_data  = data_mem[{rd_idx, rd_word}];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/ysyx_24100029_icache.sv
// Blocking direct-mapped instruction cache: IFU read slave in front, AXI4 burst
// refill master behind, one request in flight on each side.
module ysyx_24100029_icache #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fence_i,
    output logic        busy,
    input  logic        s_arvalid,
    output logic        s_arready,
    input  logic [31:0] s_araddr,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rlast,
    output logic        m_arvalid,
    input  logic        m_arready,
    output logic [31:0] m_araddr,
    output logic [3:0]  m_arid,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    input  logic        m_rvalid,
    output logic        m_rready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast
);
    import ysyx_24100029_pkg::*;

    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 30 - IDX_W - WORD_W;
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    icache_state_t     state;
    logic [29:0]       addr_q;
    logic [WORD_W-1:0] beat_cnt;
    logic              beat_err;
    logic              fenced;
    logic [31:0]       word_buf;

    logic [WORD_W-1:0] addr_word;
    logic [IDX_W-1:0]  addr_idx;
    logic [TAG_W-1:0]  addr_tag;
    logic [31:0]       rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic              rd_valid;
    logic              hit;
    logic              beat_fire;
    logic              beat_bad;
    logic              refill_err;
    logic              last_fire;
    logic [31:0]       req_word;
    logic              unused_addr_bits;

    assign addr_word = addr_q[WORD_W-1:0];
    assign addr_idx  = addr_q[WORD_W +: IDX_W];
    assign addr_tag  = addr_q[29 -: TAG_W];
    assign hit       = rd_valid && (rd_tag == addr_tag);

    // A beat is bad on a non-OKAY response or when rlast disagrees with the beat count.
    assign beat_fire  = (state == S_REFILL_R) && m_rvalid;
    assign beat_bad   = (m_rresp != RESP_OKAY) || (m_rlast != (beat_cnt == LAST_BEAT));
    assign refill_err = beat_err || beat_bad;
    assign last_fire  = beat_fire && m_rlast;
    assign req_word   = (beat_cnt == addr_word) ? m_rdata : word_buf;

    assign busy      = (state != S_IDLE);
    assign s_arready = (state == S_IDLE);
    assign s_rlast   = s_rvalid;
    assign m_rready  = (state == S_REFILL_R);
    assign m_araddr  = {addr_q[29:WORD_W], {(WORD_W + 2){1'b0}}};
    assign m_arid    = 4'd0;
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;
    assign unused_addr_bits = ^s_araddr[1:0];

    ysyx_24100029_icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clock      (clock),
        .reset      (reset),
        .inval_all  (fence_i),
        .word_we    (beat_fire),
        .wr_idx     (addr_idx),
        .wr_word    (beat_cnt),
        .wr_data    (m_rdata),
        .line_we    (last_fire),
        .line_tag   (addr_tag),
        .line_valid (!refill_err && !fenced && !fence_i),
        .rd_idx     (addr_idx),
        .rd_word    (addr_word),
        .rd_data    (rd_data),
        .rd_tag     (rd_tag),
        .rd_valid   (rd_valid)
    );

    always_ff @(posedge clock) begin
        if ((state == S_IDLE) && s_arvalid) addr_q <= s_araddr[31:2];
        if (beat_fire && (beat_cnt == addr_word)) word_buf <= m_rdata;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            beat_cnt  <= '0;
            beat_err  <= 1'b0;
            fenced    <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= 32'd0;
            s_rresp   <= RESP_OKAY;
            m_arvalid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (s_arvalid) state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    if (hit) begin
                        state    <= S_RESP;
                        s_rvalid <= 1'b1;
                        s_rdata  <= rd_data;
                        s_rresp  <= RESP_OKAY;
                    end else begin
                        state     <= S_REFILL_AR;
                        m_arvalid <= 1'b1;
                    end
                end
                S_REFILL_AR: begin
                    if (m_arready) begin
                        state     <= S_REFILL_R;
                        m_arvalid <= 1'b0;
                        beat_cnt  <= '0;
                        beat_err  <= 1'b0;
                        fenced    <= fence_i;
                    end
                end
                S_REFILL_R: begin
                    if (fence_i) fenced <= 1'b1;
                    if (m_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_bad) beat_err <= 1'b1;
                        if (m_rlast) begin
                            state    <= S_RESP;
                            s_rvalid <= 1'b1;
                            s_rdata  <= refill_err ? 32'd0 : req_word;
                            s_rresp  <= refill_err ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                S_RESP: begin
                    if (s_rready) begin
                        state    <= S_IDLE;
                        s_rvalid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24100029_icache.sv
// Randomized scoreboard bench for the instruction cache: a line-level reference model
// predicts hit/miss and response, an AXI slave serves refills, a monitor checks responses.
module tb_ysyx_24100029_icache;

    logic        clock;
    logic        reset;
    logic        fence_i, fence_a, fence_b;
    logic        busy;
    logic        s_arvalid, s_arready;
    logic [31:0] s_araddr;
    logic        s_rvalid, s_rready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        m_arvalid, m_arready;
    logic [31:0] m_araddr;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_rvalid, m_rready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rlast;

    assign fence_i = fence_a | fence_b;

    ysyx_24100029_icache dut (
        .clock(clock), .reset(reset), .fence_i(fence_i), .busy(busy),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rlast(m_rlast)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [31:0] line;
        int          err_beat;
        bit          early;
        int          fence_beat;
    } cfg_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          hit;
    } exp_t;

    cfg_t  cfg_q[$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    ar_seen = 0;
    int    exp_misses = 0;
    int    hold_next = -1;
    int    cyc = 0;
    int    ar_cyc = 0;

    // Reference model: per-line valid bit and tag
    logic [15:0] mvalid;
    logic [23:0] mtag [16];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic abort(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout (t=%0t)", name, $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic fence_idle();
        fence_a = 1'b1;
        @(negedge clock);
        fence_a = 1'b0;
        mvalid = '0;
    endtask

    // Called at a negedge with the cache idle; returns at a negedge after the response.
    task automatic fetch(input logic [31:0] a, input int err_beat, input bit early,
                         input int fence_beat, input int hold);
        logic [3:0]  idx;
        logic [23:0] tag;
        exp_t        e;
        cfg_t        c;
        bit          bad;
        idx = a[7:4];
        tag = a[31:8];
        e.hit = mvalid[idx] && (mtag[idx] == tag);
        if (e.hit) begin
            e.data = mem_word(a);
            e.resp = 2'b00;
        end else begin
            c.line = {a[31:4], 4'h0};
            c.err_beat = err_beat;
            c.early = early;
            c.fence_beat = fence_beat;
            cfg_q.push_back(c);
            exp_misses++;
            bad = (err_beat >= 0) || early;
            e.data = bad ? 32'd0 : mem_word(a);
            e.resp = bad ? 2'b10 : 2'b00;
            if (fence_beat >= 0) mvalid = '0;
            else if (bad) mvalid[idx] = 1'b0;
            else begin
                mvalid[idx] = 1'b1;
                mtag[idx] = tag;
            end
        end
        hold_next = hold;
        exp_q.push_back(e);
        s_araddr = a;
        s_arvalid = 1'b1;
        for (int w = 0; !s_arready; w++) begin
            if (w > 100) abort("ar_accept");
            @(negedge clock);
        end
        @(negedge clock);
        s_arvalid = 1'b0;
        s_araddr = $urandom;
        for (int w = 0; exp_q.size() != 0; w++) begin
            if (w > 400) abort("response");
            @(negedge clock);
        end
    endtask

    // IFU side: accepts responses after a random (or forced) number of stall cycles
    initial begin
        int  hold;
        bit  in_resp;
        hold = 0;
        in_resp = 0;
        s_rready = 1'b0;
        forever begin
            @(negedge clock);
            if (s_rvalid) begin
                if (!in_resp) begin
                    in_resp = 1;
                    hold = (hold_next >= 0) ? hold_next : int'($urandom_range(0, 2));
                    hold_next = -1;
                end
                if (hold > 0) begin
                    s_rready = 1'b0;
                    hold--;
                end else begin
                    s_rready = 1'b1;
                end
            end else begin
                in_resp = 0;
                s_rready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Memory side: AXI4 slave serving refill bursts as scripted by cfg_q
    initial begin
        cfg_t cur;
        int   nb;
        m_arready = 1'b0;
        m_rvalid = 1'b0;
        m_rdata = 32'd0;
        m_rresp = 2'b00;
        m_rlast = 1'b0;
        fence_b = 1'b0;
        forever begin
            @(negedge clock);
            m_arready = 1'b0;
            if (reset && m_arvalid) begin
                m_arready = ($urandom_range(0, 2) != 0);
                if (m_arready) begin
                    ar_seen++;
                    chk("refill_expected", 32'(cfg_q.size() != 0), 32'd1);
                    if (cfg_q.size() != 0) cur = cfg_q.pop_front();
                    else begin
                        cur.line = m_araddr;
                        cur.err_beat = -1;
                        cur.early = 0;
                        cur.fence_beat = -1;
                    end
                    chk("m_araddr", m_araddr, cur.line);
                    chk("m_arlen", 32'(m_arlen), 32'd3);
                    chk("m_arsize", 32'(m_arsize), 32'd2);
                    chk("m_arburst", 32'(m_arburst), 32'd1);
                    chk("m_arid", 32'(m_arid), 32'd0);
                    @(negedge clock);
                    m_arready = 1'b0;
                    nb = cur.early ? 3 : 4;
                    for (int b = 0; b < nb; b++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            m_rvalid = 1'b0;
                            @(negedge clock);
                        end
                        m_rvalid = 1'b1;
                        m_rdata = mem_word(cur.line + 32'(4 * b));
                        m_rresp = (b == cur.err_beat) ? ($urandom_range(0, 1) ? 2'b10 : 2'b11) : 2'b00;
                        m_rlast = (b == nb - 1);
                        fence_b = (b == cur.fence_beat);
                        for (int w = 0; !m_rready; w++) begin
                            if (w > 50) abort("m_rready");
                            @(negedge clock);
                        end
                        @(negedge clock);
                        m_rvalid = 1'b0;
                        m_rlast = 1'b0;
                        m_rresp = 2'b00;
                        fence_b = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compares each presented response with the scoreboard head
    initial begin
        exp_t        cur;
        bit          in_resp;
        bit          pend_hold;
        logic [31:0] held_data;
        logic [1:0]  held_resp;
        in_resp = 0;
        pend_hold = 0;
        held_data = 32'd0;
        held_resp = 2'b00;
        forever begin
            @(negedge clock);
            #1;
            cyc++;
            if (reset) begin
                chk("busy", 32'(busy), 32'(!s_arready));
                if (s_arvalid && s_arready) ar_cyc = cyc;
                if (pend_hold) begin
                    chk("hold_rvalid", 32'(s_rvalid), 32'd1);
                    chk("hold_rdata", s_rdata, held_data);
                    chk("hold_rresp", 32'(s_rresp), 32'(held_resp));
                end
                if (s_rvalid) begin
                    chk("arready_in_resp", 32'(s_arready), 32'd0);
                    chk("s_rlast", 32'(s_rlast), 32'd1);
                    if (!in_resp) begin
                        in_resp = 1;
                        chk("resp_expected", 32'(exp_q.size() != 0), 32'd1);
                        if (exp_q.size() != 0) begin
                            cur = exp_q[0];
                            chk("s_rdata", s_rdata, cur.data);
                            chk("s_rresp", 32'(s_rresp), 32'(cur.resp));
                            if (cur.hit) chk("hit_latency", 32'(cyc - ar_cyc), 32'd2);
                        end
                    end
                    if (s_rready) begin
                        if (exp_q.size() != 0) exp_q.delete(0);
                        in_resp = 0;
                        pend_hold = 0;
                    end else begin
                        pend_hold = 1;
                        held_data = s_rdata;
                        held_resp = s_rresp;
                    end
                end else begin
                    chk("s_rlast_idle", 32'(s_rlast), 32'd0);
                    pend_hold = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int          eb, fb, nb;
        bit          early;
        reset = 1'b0;
        s_arvalid = 1'b0;
        s_araddr = 32'd0;
        fence_a = 1'b0;
        mvalid = '0;
        repeat (3) @(negedge clock);
        chk("rst_s_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_s_rdata", s_rdata, 32'd0);
        chk("rst_s_rresp", 32'(s_rresp), 32'd0);
        chk("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_m_rready", 32'(m_rready), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_s_arready", 32'(s_arready), 32'd1);

        fetch(32'h3000_0000, -1, 0, -1, -1);
        fetch(32'h3000_0008, -1, 0, -1, -1);
        fence_idle();
        fetch(32'h3000_000C, -1, 0, -1, -1);
        fetch(32'h3000_0100, -1, 0, -1, -1);
        fetch(32'h3000_0000, -1, 0, -1, -1);
        fetch(32'h3000_0040,  1, 0, -1, -1);
        fetch(32'h3000_0040, -1, 0, -1, -1);
        fetch(32'h3000_0044, -1, 0, -1, -1);
        fence_idle();
        fetch(32'h3000_0000, -1, 0, -1, -1);
        fetch(32'h3000_0050, -1, 0,  3, -1);
        fetch(32'h3000_0050, -1, 0, -1, -1);
        fetch(32'h3000_0054, -1, 0, -1,  5);
        fetch(32'h3000_0060, -1, 1, -1, -1);
        fetch(32'h3000_0070, -1, 0,  1, -1);
        fetch(32'h3000_0054, -1, 0, -1, -1);

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0) fence_idle();
            a = 32'h3000_0000 + ($urandom_range(0, 1) << 8) + ($urandom_range(0, 63) << 2)
                + $urandom_range(0, 3);
            early = ($urandom_range(0, 15) == 0);
            nb = early ? 3 : 4;
            eb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, nb - 1)) : -1;
            fetch(a, eb, early, fb, ($urandom_range(0, 15) == 0) ? 4 : -1);
        end

        repeat (5) @(negedge clock);
        chk("refill_count", 32'(ar_seen), 32'(exp_misses));
        chk("refills_drained", 32'(cfg_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
